// File: rtl/popcount06_weight_enum.sv
// Enumerates every N-bit vector of Hamming weight k in ascending order, one per output handshake.
// Optional macro POPCOUNT_ENUM_SELFCHECK_EN adds a sticky o_chk_fail weight monitor.
module popcount06_weight_enum #(
    parameter int N  = 6,
    parameter int CW = 3,
    parameter int IW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cnt_valid,
    output logic          o_cnt_ready,
    input  logic [CW-1:0] i_cnt,
    output logic          o_vec_valid,
    input  logic          i_vec_ready,
    output logic [N-1:0]  o_vec,
    output logic [IW-1:0] o_vec_idx,
    output logic          o_vec_last,
`ifdef POPCOUNT_ENUM_SELFCHECK_EN
    output logic          o_chk_fail,
`endif
    output logic          o_cnt_err
);

    localparam int ZW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CW = CW'(N);

    typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

    state_t        r_state;
    logic [N-1:0]  r_vec;
    logic [IW-1:0] r_idx;
    logic          r_last;
    logic          r_valid;
    logic          r_cnt_err;
    logic [CW-1:0] r_k;

    logic [ZW-1:0] w_ctz;
    logic [N:0]    w_x, w_t, w_t1, w_low, w_next_full;
    logic [N-1:0]  w_next;
    logic [N:0]    w_lo_k, w_top_k, w_lo_cnt;
    logic [N-1:0]  w_last_pat;
    logic          w_accept;

    always_comb begin
        w_ctz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_vec[i]) w_ctz = ZW'(i);
        end
    end

    // Gosper step in N+1 bits so the carry out of the top bit is not lost
    always_comb begin
        w_x         = {1'b0, r_vec};
        w_t         = w_x | (w_x - 1'b1);
        w_t1        = w_t + 1'b1;
        w_low       = ((~w_t) & w_t1) - 1'b1;
        w_next_full = w_t1 | (w_low >> ({1'b0, w_ctz} + 1'b1));
        w_next      = w_next_full[N-1:0];
    end

    always_comb begin
        w_lo_k     = ({{N{1'b0}}, 1'b1} << r_k) - 1'b1;
        w_top_k    = w_lo_k << (N_CW - r_k);
        w_last_pat = w_top_k[N-1:0];
        w_lo_cnt   = ({{N{1'b0}}, 1'b1} << i_cnt) - 1'b1;
    end

    assign o_cnt_ready = (r_state == S_IDLE) && !i_rst;
    assign w_accept    = i_cnt_valid && o_cnt_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_vec     <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
            r_cnt_err <= 1'b0;
            r_k       <= '0;
        end else begin
            r_cnt_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_cnt > N_CW) begin
                            r_cnt_err <= 1'b1;
                        end else begin
                            r_k     <= i_cnt;
                            r_vec   <= w_lo_cnt[N-1:0];
                            r_idx   <= '0;
                            r_last  <= (i_cnt == '0) || (i_cnt == N_CW);
                            r_valid <= 1'b1;
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_vec_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_vec  <= w_next;
                            r_idx  <= r_idx + 1'b1;
                            r_last <= (w_next == w_last_pat);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_vec_valid = r_valid;
    assign o_vec       = r_vec;
    assign o_vec_idx   = r_idx;
    assign o_vec_last  = r_last;
    assign o_cnt_err   = r_cnt_err;

`ifdef POPCOUNT_ENUM_SELFCHECK_EN
    logic [CW-1:0] w_pop;
    logic          r_chk_fail;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + CW'(r_vec[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chk_fail <= 1'b0;
        end else if (r_valid && (w_pop != r_k)) begin
            r_chk_fail <= 1'b1;
        end
    end

    assign o_chk_fail = r_chk_fail;
`endif

endmodule
